// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures selected register-file writes with a cycle
// timestamp into a first-word-fall-through FIFO for an external consumer.
module wb_trace_buffer #(
  parameter int                    WORD_W       = 32,
  parameter int                    ADDR_W       = 4,
  parameter int                    DEPTH        = 8,
  parameter int                    STAMP_W      = 16,
  parameter logic [2**ADDR_W-1:0]  CAPTURE_MASK = 16'h0001
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wb_write_en_i,
  input  logic [ADDR_W-1:0]        wb_dest_addr_i,
  input  logic [WORD_W-1:0]        wb_data_i,
  input  logic                     trace_enable_i,
  input  logic                     clear_i,
  input  logic                     trace_ready_i,
  output logic                     trace_valid_o,
  output logic [ADDR_W-1:0]        trace_addr_o,
  output logic [WORD_W-1:0]        trace_data_o,
  output logic [STAMP_W-1:0]       trace_stamp_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [15:0]              overflow_cnt_o,
  output logic [WORD_W-1:0]        last_data_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + WORD_W + STAMP_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        ovf_q, ovf_d;
  logic [WORD_W-1:0]  last_q, last_d;
  logic [STAMP_W-1:0] stamp_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic qualify, is_full, is_empty, pop, push, drop;

  assign qualify  = trace_enable_i & wb_write_en_i & CAPTURE_MASK[wb_dest_addr_i];
  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign pop      = ~is_empty & trace_ready_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = qualify & (~is_full | pop) & ~clear_i;
  assign drop     = qualify & is_full & ~pop & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    if (qualify) last_d = wb_data_i;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (drop) ovf_d = sat_inc16(ovf_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      last_q   <= '0;
      stamp_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      stamp_q  <= stamp_q + STAMP_W'(1);
    end
  end

  // Entry storage carries no reset; the head is only meaningful while valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wr_ptr_q] <= {wb_dest_addr_i, wb_data_i, stamp_q};
  end

  assign trace_valid_o  = ~is_empty;
  assign trace_addr_o   = mem_q[rd_ptr_q][ENTRY_W-1 -: ADDR_W];
  assign trace_data_o   = mem_q[rd_ptr_q][STAMP_W +: WORD_W];
  assign trace_stamp_o  = mem_q[rd_ptr_q][STAMP_W-1:0];
  assign count_o        = count_q;
  assign full_o         = is_full;
  assign empty_o        = is_empty;
  assign overflow_cnt_o = ovf_q;
  assign last_data_o    = last_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue scoreboard of expected entries.
module tb_wb_trace_buffer;

  localparam int WORD_W = 32, ADDR_W = 4, DEPTH = 8, STAMP_W = 16;
  localparam logic [15:0] MASK = 16'h0001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we, en, clr, rdy;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data;
  logic              valid, full, empty;
  logic [ADDR_W-1:0] t_addr;
  logic [WORD_W-1:0] t_data, last;
  logic [STAMP_W-1:0] t_stamp;
  logic [3:0]        count;
  logic [15:0]       ovf;

  wb_trace_buffer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W),
                    .CAPTURE_MASK(MASK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_write_en_i(we), .wb_dest_addr_i(addr),
    .wb_data_i(data), .trace_enable_i(en), .clear_i(clr), .trace_ready_i(rdy),
    .trace_valid_o(valid), .trace_addr_o(t_addr), .trace_data_o(t_data),
    .trace_stamp_o(t_stamp), .count_o(count), .full_o(full), .empty_o(empty),
    .overflow_cnt_o(ovf), .last_data_o(last));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [WORD_W-1:0]  d;
    logic [STAMP_W-1:0] s;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  int          stamp_m = 0;
  logic [15:0] ovf_m = 0;
  logic [31:0] last_m = 0;

  always @(posedge clk) begin
    if (!rst_n) stamp_m = 0;
    else        stamp_m = (stamp_m + 1) % (1 << STAMP_W);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(sb.size()));
    chk({tag, ".valid"}, 64'(valid), 64'(sb.size() != 0));
    chk({tag, ".empty"}, 64'(empty), 64'(sb.size() == 0));
    chk({tag, ".full"},  64'(full),  64'(sb.size() == DEPTH));
    chk({tag, ".ovf"},   64'(ovf),   64'(ovf_m));
    chk({tag, ".last"},  64'(last),  64'(last_m));
  endtask

  // One clock: inputs applied at negedge, scoreboard updated, state checked next negedge.
  task automatic step(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [WORD_W-1:0] d, input logic e, input logic r, input logic c);
    logic   q, p;
    entry_t ex;
    we = w; addr = a; data = d; en = e; rdy = r; clr = c;
    q = w && e && MASK[a];
    p = r && (sb.size() != 0);
    if (p) begin
      ex = sb[0];
      chk({tag, ".head_addr"},  64'(t_addr),  64'(ex.a));
      chk({tag, ".head_data"},  64'(t_data),  64'(ex.d));
      chk({tag, ".head_stamp"}, 64'(t_stamp), 64'(ex.s));
    end
    if (q) last_m = d;
    if (c) begin
      sb.delete();
      ovf_m = 0;
    end else begin
      if (p) void'(sb.pop_front());
      if (q) begin
        if (sb.size() < DEPTH) sb.push_back('{a: a, d: d, s: STAMP_W'(stamp_m)});
        else if (ovf_m != 16'hFFFF) ovf_m++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    we = 0; en = 0; rdy = 0; clr = 0;
    chk_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0; we = 0; en = 0; rdy = 0; clr = 0; addr = 0; data = 0;
    @(posedge clk);
    @(negedge clk);
    sb.delete(); ovf_m = 0; last_m = 0;
    chk_state(tag);
    rst_n = 1;
  endtask

  initial begin
    int guard;
    rst_n = 0; we = 0; en = 0; rdy = 0; clr = 0; addr = 0; data = 0;
    @(negedge clk);
    do_reset("reset");

    // Idle until the stamp reaches 5, then capture a write to r0.
    guard = 0;
    while (stamp_m != 5 && guard < 20) begin
      step("idle", 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("stamp_reach", 64'(stamp_m), 64'd5);
    step("w_r0", 1, 0, 32'hDEADBEEF, 1, 0, 0);
    chk("first.data",  64'(t_data),  64'hDEADBEEF);
    chk("first.stamp", 64'(t_stamp), 64'd5);
    chk("first.addr",  64'(t_addr),  64'd0);
    step("drain1", 0, 0, 0, 0, 1, 0);
    step("rdy_empty", 0, 0, 0, 0, 1, 0);

    // Unmasked register, disabled capture and no-strobe writes are ignored.
    step("w_r3", 1, 3, 32'h33333333, 1, 0, 0);
    step("w_dis", 1, 0, 32'h44444444, 0, 0, 0);
    step("w_nowe", 0, 0, 32'h55555555, 1, 0, 0);

    // Ten writes into an eight-entry FIFO with the consumer stalled.
    for (int i = 0; i < 10; i++) step("fill", 1, 0, 32'hA000_0000 + i, 1, 0, 0);
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.ovf",  64'(ovf),  64'd2);

    // Push and pop while full: occupancy holds, the new entry lands at the tail.
    step("full_pp", 1, 0, 32'hBBBB_0001, 1, 1, 0);
    chk("full_pp.count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) step("drain", 0, 0, 0, 0, 1, 0);

    // Clear with three entries stored and a coincident qualifying write.
    for (int i = 0; i < 3; i++) step("pre_clr", 1, 0, 32'hC000_0000 + i, 1, 0, 0);
    step("clear", 1, 0, 32'hCCCC_1234, 1, 1, 1);
    chk("clear.last", 64'(last), 64'hCCCC_1234);
    chk("clear.count", 64'(count), 64'd0);

    // Reset mid-operation with five entries stored.
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 32'hD000_0000 + i, 1, 0, 0);
    do_reset("mid_reset");
    step("post_rst", 1, 0, 32'hE000_0000, 1, 0, 0);
    chk("post_rst.stamp", 64'(t_stamp), 64'd0);
    step("post_rst_drain", 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter WORD_W, default 32, width of the write-back data and trace data.
REQ-002 Parameter ADDR_W, default 4, width of the register address.
REQ-003 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 Parameter STAMP_W, default 16, width of the cycle timestamp.
REQ-005 Parameter CAPTURE_MASK, default 16'h0001, width 2**ADDR_W; bit n set means writes to register n are traced.
REQ-006 Clock  in  1  single clock; all state changes on the rising edge.
REQ-007 Reset  in  1  synchronous, active-low reset.
REQ-008 wb_write_en_i  in  1  register-file write strobe from the write-back stage.
REQ-009 wb_dest_addr_i  in  ADDR_W  destination register of the write.
REQ-010 wb_data_i  in  WORD_W  data being written.
REQ-011 trace_enable_i  in  1  capture enable.
REQ-012 clear_i  in  1  synchronous flush of the FIFO and the overflow counter.
REQ-013 trace_ready_i  in  1  consumer accepts the head entry.
REQ-014 trace_valid_o  out  1  head entry present.
REQ-015 trace_addr_o  out  ADDR_W  head entry register address.
REQ-016 trace_data_o  out  WORD_W  head entry data.
REQ-017 trace_stamp_o  out  STAMP_W  head entry timestamp.
REQ-018 count_o  out  log2(DEPTH)+1  number of occupied entries.
REQ-019 full_o, empty_o  out  1 each  count_o equals DEPTH; count_o equals 0.
REQ-020 overflow_cnt_o  out  16  dropped-capture counter; saturates at 16'hFFFF.
REQ-021 last_data_o  out  WORD_W  data of the most recent qualifying write.

Function
REQ-022 A qualifying write SHALL be trace_enable_i=1, wb_write_en_i=1 and CAPTURE_MASK[wb_dest_addr_i]=1 in the same cycle.
REQ-023 A free-running stamp counter SHALL increment every cycle out of reset and wrap from all-ones to 0; clear_i SHALL NOT affect it.
REQ-024 A qualifying write SHALL push {wb_dest_addr_i, wb_data_i, current stamp} at that edge, provided the FIFO is not full, or is full and a pop occurs in the same cycle.
REQ-025 A pop SHALL occur on trace_valid_o=1 and trace_ready_i=1; trace_ready_i SHALL be ignored while empty.
REQ-026 The FIFO SHALL be first-word-fall-through: trace_valid_o rises the cycle after a push into an empty FIFO; head fields are stable while trace_valid_o=1 and no pop occurs.
REQ-027 A simultaneous push and pop SHALL leave count_o unchanged at any occupancy, including full.
REQ-028 A qualifying write while full with no pop SHALL be dropped, and overflow_cnt_o SHALL increment by 1, saturating at 16'hFFFF.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 last_data_o SHALL load wb_data_i on every qualifying write, including dropped writes.
REQ-031 clear_i=1 SHALL, at that edge, set count_o to 0, reset both pointers and zero overflow_cnt_o.
REQ-032 A push coincident with clear_i SHALL be discarded; last_data_o still updates.
REQ-033 A pop coincident with clear_i SHALL be superseded by the clear.
REQ-034 All outputs SHALL be driven from registers or FIFO storage, with no combinational path from any input to any output.

Reset
REQ-035 Reset=0 at an edge SHALL zero the pointers, count_o, overflow_cnt_o, last_data_o and the stamp counter, giving trace_valid_o=0, empty_o=1 and full_o=0.
REQ-036 While Reset=0, no push, pop or counter update SHALL occur.
REQ-037 Reset asserted mid-operation SHALL discard all stored entries.
REQ-038 Storage contents need not be reset; trace_addr_o, trace_data_o and trace_stamp_o are don't-care while trace_valid_o=0.

Verification
REQ-039 Reset release; write to r0 of 32'hDEADBEEF at stamp 5 -> the next cycle shows trace_valid_o=1, trace_addr_o=0, trace_data_o=32'hDEADBEEF, trace_stamp_o=5, last_data_o=32'hDEADBEEF.
REQ-040 Default mask; write to r3 -> no push, count_o remains 0 and last_data_o is unchanged.
REQ-041 trace_ready_i=0; 10 qualifying writes at DEPTH=8 -> full_o=1, count_o=8, overflow_cnt_o=2; draining returns the first 8 entries in order.
REQ-042 FIFO full; push and pop in the same cycle -> count_o stays 8, overflow_cnt_o is unchanged, and the new entry arrives last.
REQ-043 Count of 3 entries; clear_i coincident with a qualifying write -> next cycle count_o=0, empty_o=1, overflow_cnt_o=0, and last_data_o equals the new data.
REQ-044 Reset pulsed low for 1 cycle with 5 entries stored -> trace_valid_o=0, count_o=0, and the stamp restarts from 0.
